alu_rf_exec: RTL and testbench
==============================

Name: alu_rf_exec

Overview:
Parametrised execution unit that merges the ALU and register file into one sequenced datapath. An instruction handshake drives it, so external logic no longer pokes the register file. Each instruction reads rs/rt, executes, and writes back to rd under an FSM. It adds a multi-cycle multiply, a hardwired-zero r0, illegal-op detection and a debug read port.

Parameters:
WIDTH, 32, datapath and register width in bits (>=4)
ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W
CNT_W, 6, multiply iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present on control/rs/rt/rd/we
instr_ready  out  1  unit can accept an instruction
control  in  4  ALU op: 0 and, 1 or, 2 add, 3 mul (low half), 6 sub, 7 slt, C nor
rs  in  ADDR_W  source A register
rt  in  ADDR_W  source B register
rd  in  ADDR_W  destination register
we  in  1  write result to rd
done  out  1  one-cycle pulse: instruction retired, result/flags valid
result  out  WIDTH  last retired result (held until next done)
cout  out  1  carry-out of last add/sub
zero  out  1  last result == 0
overflow  out  1  signed overflow (add/sub) or unsigned product overflow (mul)
illegal  out  1  one-cycle pulse alongside done for an unsupported control code
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  WIDTH  combinational read of rf[dbg_addr]; r0 reads 0

Behaviour:
- Reset, asynchronous on reset_n low:
  - FSM goes to IDLE; all registers r0..rN-1 clear to 0.
  - result, cout, zero, overflow, done and illegal clear to 0; instr_ready = 1 once reset_n is high.
- FSM states are IDLE and EXEC. instr_ready is 1 only in IDLE.
- IDLE:
  - Accept at a rising edge when instr_valid && instr_ready.
  - On accept, latch opA = rf[rs], opB = rf[rt], control, rd and we, then go to EXEC.
  - If rs or rt is 0, the operand is 0.
- EXEC, single-cycle ops (0, 1, 2, 6, 7, C):
  - Compute on the next edge. Register result and flags, write back, pulse done, return to IDLE.
  - Latency: accept at edge E0 gives done high in the cycle after edge E1. Throughput is one instruction per 2 cycles.
- EXEC, mul (3):
  - Unsigned shift-add over exactly WIDTH cycles, with the counter counting 0..WIDTH-1.
  - Retires at edge E_WIDTH, so done is high in the cycle after that edge.
  - result is the low WIDTH bits of the product. overflow = 1 if the upper WIDTH bits are nonzero; cout = 0.
- Arithmetic rules:
  - add: cout is the carry out of bit WIDTH-1; overflow = (sA == sB) && (sR != sA).
  - sub: computed as A + ~B + 1; cout is that carry (1 = no borrow); overflow = (sA != sB) && (sR != sA).
  - slt: signed A < B gives 1, else 0.
  - and, or, nor and slt force cout = 0 and overflow = 0.
  - zero = (result == 0) for every op.
- Writeback:
  - rf[rd] is written at the retire edge only if we = 1, rd != 0 and the op is legal.
  - Writes to r0 are discarded.
- Illegal control code:
  - Retires after 1 EXEC cycle with result = 0, zero = 1, cout = 0, overflow = 0.
  - No write occurs; illegal pulses together with done.
- Hazards: writeback completes before the next accept edge, so back-to-back dependent instructions read updated values with no forwarding needed.
- Input signals are ignored outside the accept edge. Changing control/rs/rt during EXEC has no effect.
- Reset mid-EXEC, including mid-multiply, aborts the instruction: no writeback, no done, registers cleared.
- The dbg_data path is purely combinational and unaffected by the FSM.

Test Plan:
- Reset: hold reset_n low for 3 cycles then release -> instr_ready = 1, done = 0, result = 0, dbg_data = 0 for every dbg_addr.
- Add with overflow (WIDTH = 32): rf[1] = 7FFFFFFF, rf[2] = 1; add rd = 3 -> done 2 cycles after accept, result = 80000000, overflow = 1, cout = 0, rf[3] = 80000000.
- Sub and slt:
  - rf[3] = 4, rf[2] = 16; sub rd = 5 rs = 3 rt = 2 -> result = FFFFFFF4, cout = 0, overflow = 0.
  - Then slt rd = 6 rs = 5 rt = 0 -> rf[6] = 1, zero = 0.
- Decrement loop: rf[3] = 4, rf[1] = 1, rf[2] = 16; repeat add r4 += r2, sub r3 -= r1, slt r5 = r3 < r0 until r5 = 1 -> rf[4] = 80 (5 iterations, r3 ending at -1), rf[3] = FFFFFFFF.
- Multiply:
  - mul 16 * 4 -> done exactly WIDTH + 1 cycles after the accept edge, result = 64, overflow = 0.
  - mul 10000 * 10000 (hex) -> result = 0, overflow = 1, zero = 1.
- r0, illegal op, abort:
  - add rd = 0 -> rf[0] reads 0.
  - control = 4'hF -> illegal and done pulse together, no register changes.
  - reset_n low 5 cycles into a mul -> no done, all registers 0, instr_ready = 1 after release.

Source files
------------

// File: rtl/alu_rf_exec.sv
// alu_rf_exec: handshaked ALU + register file execution unit with shift-add multiply
module alu_rf_exec #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        control,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              cout,
    output logic              zero,
    output logic              overflow,
    output logic              illegal,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);
    localparam int NREGS = 2**ADDR_W;
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] op_a, op_b, p_hi, alu_res;
    logic [3:0] ctl;
    logic [ADDR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0] arith, mul_sum;
    logic we_q, accept, retire, legal, is_sub, alu_c, alu_ov;
    assign instr_ready = state == IDLE;
    assign accept = instr_valid && instr_ready;
    assign legal = ctl inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hC};
    assign retire = state == EXEC && (ctl != 4'h3 || cnt == CNT_W'(WIDTH-1));
    assign is_sub = ctl == 4'h6;
    assign arith = {1'b0, op_a} + {1'b0, is_sub ? ~op_b : op_b} + {{WIDTH{1'b0}}, is_sub};
    assign mul_sum = {1'b0, p_hi} + (op_b[0] ? {1'b0, op_a} : '0);
    assign dbg_data = dbg_addr == '0 ? '0 : rf[dbg_addr];
    always_comb begin
        alu_res = '0;
        alu_c = 1'b0;
        alu_ov = 1'b0;
        case (ctl)
            4'h0: alu_res = op_a & op_b;
            4'h1: alu_res = op_a | op_b;
            4'h2, 4'h6: begin
                alu_res = arith[WIDTH-1:0];
                alu_c = arith[WIDTH];
                alu_ov = (is_sub ? op_a[WIDTH-1] != op_b[WIDTH-1] : op_a[WIDTH-1] == op_b[WIDTH-1])
                         && arith[WIDTH-1] != op_a[WIDTH-1];
            end
            4'h3: begin
                alu_res = {mul_sum[0], op_b[WIDTH-1:1]};
                alu_ov = |mul_sum[WIDTH:1];
            end
            4'h7: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'hC: alu_res = ~(op_a | op_b);
            default: ;
        endcase
    end
    always_comb state_nx = accept ? EXEC : retire ? IDLE : state;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rf <= '{default: '0};
            op_a <= '0;
            op_b <= '0;
            p_hi <= '0;
            ctl <= '0;
            rd_q <= '0;
            we_q <= 1'b0;
            cnt <= '0;
            done <= 1'b0;
            illegal <= 1'b0;
            result <= '0;
            cout <= 1'b0;
            zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            done <= retire;
            illegal <= retire && !legal;
            if (accept) begin
                op_a <= rs == '0 ? '0 : rf[rs];
                op_b <= rt == '0 ? '0 : rf[rt];
                ctl <= control;
                rd_q <= rd;
                we_q <= we;
                p_hi <= '0;
                cnt <= '0;
            end else if (state == EXEC && !retire) begin
                p_hi <= mul_sum[WIDTH:1];
                op_b <= {mul_sum[0], op_b[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
            if (retire) begin
                result <= alu_res;
                cout <= alu_c;
                zero <= alu_res == '0;
                overflow <= alu_ov;
                if (we_q && rd_q != '0 && legal) rf[rd_q] <= alu_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_rf_exec.sv
// tb_alu_rf_exec: directed-vector bench for alu_rf_exec
module tb_alu_rf_exec;
    localparam int W = 32;
    logic clk = 1'b0, reset_n = 1'b0, instr_valid = 1'b0, we = 1'b0;
    logic [3:0] control = '0;
    logic [4:0] rs = '0, rt = '0, rd = '0, dbg_addr = '0;
    logic instr_ready, done, cout, zero, overflow, illegal;
    logic [W-1:0] result, dbg_data;
    int n_vec = 0, n_err = 0, lat;
    logic [W-1:0] o_res;
    logic o_c, o_z, o_ov, o_ill;
    always #5 clk = ~clk;
    alu_rf_exec #(.WIDTH(W), .ADDR_W(5), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .control(control), .rs(rs), .rt(rt), .rd(rd), .we(we), .done(done), .result(result),
        .cout(cout), .zero(zero), .overflow(overflow), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
    task automatic exec(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic w);
        int k = 0;
        while (!instr_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        control = c; rs = a; rt = b; rd = d; we = w; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0; control = 4'h2; rs = 5'd31; rt = 5'd31; rd = 5'd1; we = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_err++;
            $display("FAIL exec_timeout ctl=%h: done never seen, required within 100 cycles", c);
        end
        o_res = result; o_c = cout; o_z = zero; o_ov = overflow; o_ill = illegal;
    endtask
    task automatic load(input logic [4:0] r, input logic [W-1:0] v);
        bit started = 0;
        exec(4'h0, 5'd0, 5'd0, r, 1'b1);
        for (int i = W-1; i >= 0; i--) begin
            if (started) exec(4'h2, r, r, r, 1'b1);
            if (v[i]) begin
                exec(4'h2, r, 5'd31, r, 1'b1);
                started = 1;
            end
        end
    endtask
    task automatic rd_dbg(input logic [4:0] a, input logic [W-1:0] exp, input string nm);
        dbg_addr = a;
        #1;
        n_vec++;
        if (dbg_data !== exp) begin
            n_err++;
            $display("FAIL %s: rf[%0d] got %h expected %h", nm, a, dbg_data, exp);
        end
    endtask
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b done=%b result=%h expected 1 0 0", instr_ready, done, result);
        end
        for (int i = 0; i < 32; i++) rd_dbg(5'(i), '0, "reset_rf");
        exec(4'hC, 5'd0, 5'd0, 5'd31, 1'b1);
        exec(4'h7, 5'd31, 5'd0, 5'd31, 1'b1);
        rd_dbg(5'd31, 32'd1, "const_one");
    endtask
    task automatic test_add_logic;
        load(5'd1, 32'h7FFF_FFFF);
        load(5'd2, 32'h1);
        exec(4'h2, 5'd1, 5'd2, 5'd3, 1'b1);
        n_vec++;
        if (lat !== 1 || o_res !== 32'h8000_0000 || o_ov !== 1'b1 || o_c !== 1'b0 || o_z !== 1'b0 || o_ill !== 1'b0) begin
            n_err++;
            $display("FAIL add_ovf: lat=%0d res=%h ov=%b c=%b z=%b ill=%b expected 1 80000000 1 0 0 0", lat, o_res, o_ov, o_c, o_z, o_ill);
        end
        rd_dbg(5'd3, 32'h8000_0000, "add_wb");
        exec(4'h6, 5'd3, 5'd2, 5'd9, 1'b1);
        n_vec++;
        if (o_res !== 32'h7FFF_FFFF || o_ov !== 1'b1 || o_c !== 1'b1) begin
            n_err++;
            $display("FAIL sub_ovf: res=%h ov=%b c=%b expected 7fffffff 1 1", o_res, o_ov, o_c);
        end
        exec(4'hC, 5'd0, 5'd0, 5'd7, 1'b1);
        exec(4'h2, 5'd7, 5'd31, 5'd8, 1'b1);
        n_vec++;
        if (o_res !== '0 || o_c !== 1'b1 || o_z !== 1'b1 || o_ov !== 1'b0) begin
            n_err++;
            $display("FAIL add_carry: res=%h c=%b z=%b ov=%b expected 0 1 1 0", o_res, o_c, o_z, o_ov);
        end
        exec(4'h6, 5'd3, 5'd2, 5'd9, 1'b1);
        exec(4'h0, 5'd1, 5'd3, 5'd10, 1'b1);
        n_vec++;
        if (o_res !== '0 || o_z !== 1'b1 || o_ov !== 1'b0 || o_c !== 1'b0) begin
            n_err++;
            $display("FAIL and: res=%h z=%b ov=%b c=%b expected 0 1 0 0", o_res, o_z, o_ov, o_c);
        end
        exec(4'h1, 5'd1, 5'd3, 5'd10, 1'b1);
        n_vec++;
        if (o_res !== 32'hFFFF_FFFF || o_z !== 1'b0) begin
            n_err++;
            $display("FAIL or: res=%h z=%b expected ffffffff 0", o_res, o_z);
        end
        exec(4'hC, 5'd1, 5'd2, 5'd11, 1'b1);
        n_vec++;
        if (o_res !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL nor: res=%h expected 80000000", o_res);
        end
    endtask
    task automatic test_sub_slt;
        load(5'd3, 32'd4);
        load(5'd2, 32'd16);
        exec(4'h6, 5'd3, 5'd2, 5'd5, 1'b1);
        n_vec++;
        if (lat !== 1 || o_res !== 32'hFFFF_FFF4 || o_c !== 1'b0 || o_ov !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow: lat=%0d res=%h c=%b ov=%b expected 1 fffffff4 0 0", lat, o_res, o_c, o_ov);
        end
        exec(4'h6, 5'd2, 5'd3, 5'd9, 1'b1);
        n_vec++;
        if (o_res !== 32'hC || o_c !== 1'b1) begin
            n_err++;
            $display("FAIL sub_noborrow: res=%h c=%b expected 0000000c 1", o_res, o_c);
        end
        exec(4'h7, 5'd5, 5'd0, 5'd6, 1'b1);
        n_vec++;
        if (o_res !== 32'd1 || o_z !== 1'b0) begin
            n_err++;
            $display("FAIL slt_true: res=%h z=%b expected 1 0", o_res, o_z);
        end
        rd_dbg(5'd6, 32'd1, "slt_wb");
        exec(4'h7, 5'd2, 5'd5, 5'd9, 1'b1);
        n_vec++;
        if (o_res !== '0 || o_z !== 1'b1) begin
            n_err++;
            $display("FAIL slt_false: res=%h z=%b expected 0 1", o_res, o_z);
        end
    endtask
    task automatic test_back_to_back;
        int iters = 0;
        load(5'd3, 32'd4);
        load(5'd1, 32'd1);
        load(5'd2, 32'd16);
        exec(4'h0, 5'd0, 5'd0, 5'd4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            exec(4'h2, 5'd4, 5'd2, 5'd4, 1'b1);
            exec(4'h6, 5'd3, 5'd1, 5'd3, 1'b1);
            exec(4'h7, 5'd3, 5'd0, 5'd5, 1'b1);
            iters++;
            if (o_res == 32'd1) break;
        end
        n_vec++;
        if (iters !== 5) begin
            n_err++;
            $display("FAIL loop_iters: got %0d expected 5", iters);
        end
        rd_dbg(5'd4, 32'd80, "loop_r4");
        rd_dbg(5'd3, 32'hFFFF_FFFF, "loop_r3");
    endtask
    task automatic test_mul;
        load(5'd1, 32'd16);
        load(5'd2, 32'd4);
        exec(4'h3, 5'd1, 5'd2, 5'd3, 1'b1);
        n_vec++;
        if (lat !== W || o_res !== 32'd64 || o_ov !== 1'b0 || o_c !== 1'b0 || o_z !== 1'b0) begin
            n_err++;
            $display("FAIL mul_small: lat=%0d res=%h ov=%b c=%b z=%b expected %0d 40 0 0 0", lat, o_res, o_ov, o_c, o_z, W);
        end
        rd_dbg(5'd3, 32'd64, "mul_wb");
        load(5'd4, 32'h1_0000);
        load(5'd5, 32'd7);
        exec(4'h3, 5'd4, 5'd4, 5'd5, 1'b1);
        n_vec++;
        if (o_res !== '0 || o_ov !== 1'b1 || o_z !== 1'b1) begin
            n_err++;
            $display("FAIL mul_ovf: res=%h ov=%b z=%b expected 0 1 1", o_res, o_ov, o_z);
        end
        rd_dbg(5'd5, '0, "mul_ovf_wb");
        exec(4'hC, 5'd0, 5'd0, 5'd7, 1'b1);
        exec(4'h3, 5'd7, 5'd7, 5'd8, 1'b1);
        n_vec++;
        if (o_res !== 32'd1 || o_ov !== 1'b1 || o_z !== 1'b0) begin
            n_err++;
            $display("FAIL mul_max: res=%h ov=%b z=%b expected 1 1 0", o_res, o_ov, o_z);
        end
    endtask
    task automatic test_r0_illegal;
        exec(4'h2, 5'd31, 5'd31, 5'd0, 1'b1);
        n_vec++;
        if (o_res !== 32'd2) begin
            n_err++;
            $display("FAIL r0_result: res=%h expected 2", o_res);
        end
        rd_dbg(5'd0, '0, "r0_write");
        exec(4'h2, 5'd31, 5'd31, 5'd6, 1'b0);
        rd_dbg(5'd6, 32'd1, "we_low");
        exec(4'hF, 5'd31, 5'd31, 5'd6, 1'b1);
        n_vec++;
        if (lat !== 1 || o_ill !== 1'b1 || o_res !== '0 || o_z !== 1'b1 || o_c !== 1'b0 || o_ov !== 1'b0) begin
            n_err++;
            $display("FAIL illegal: lat=%0d ill=%b res=%h z=%b c=%b ov=%b expected 1 1 0 1 0 0", lat, o_ill, o_res, o_z, o_c, o_ov);
        end
        rd_dbg(5'd6, 32'd1, "illegal_nowrite");
        @(posedge clk);
        #1;
        n_vec++;
        if (illegal !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_pulse: illegal=%b done=%b expected 0 0", illegal, done);
        end
    endtask
    task automatic test_abort;
        logic seen = 1'b0;
        @(negedge clk);
        control = 4'h3; rs = 5'd7; rt = 5'd7; rd = 5'd3; we = 1'b1; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (W) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        n_vec++;
        if (seen !== 1'b0 || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort: done_seen=%b ready=%b expected 0 1", seen, instr_ready);
        end
        for (int i = 0; i < 32; i++) rd_dbg(5'(i), '0, "abort_rf");
    endtask
    initial begin
        test_reset;
        test_add_logic;
        test_sub_slt;
        test_back_to_back;
        test_mul;
        test_r0_illegal;
        test_abort;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
